event_timestamper: RTL
======================

// Module: event_timestamper
// PURPOSE
//  Free-running microsecond timebase plus event capture queue, fed directly by the clock
//  manager's 48 MHz output and power-on reset pulse. Each event strobe is stamped with
//  the current timestamp and queued in a small FIFO. The trace/USB readout logic drains
//  the FIFO through a valid/ready port. Overflow is counted and flagged, never silent.
// PARAMETERS
//  PRESCALE    48   osc48m cycles per timestamp increment (48 -> 1 us); must be >= 2
//  TS_WIDTH    32   timestamp width; wraps modulo 2^TS_WIDTH
//  CODE_WIDTH  8    event code width
//  FIFO_DEPTH  8    record slots; power of 2, >= 2
//  DROP_WIDTH  8    dropped-event counter width; saturates
// PORTS
//  osc48m       in   1            clock, 48 MHz
//  reset        in   1            asynchronous, active-high reset
//  enable       in   1            1 = timebase runs; 0 = prescaler and timestamp hold
//  clear        in   1            sync: zero prescaler, timestamp, drop_count, lost flag
//  ev_valid     in   1            event strobe, sampled every rising edge
//  ev_code      in   CODE_WIDTH   event code, qualified by ev_valid
//  out_valid    out  1            head record available
//  out_ready    in   1            consumer accepts head when out_valid && out_ready
//  out_code     out  CODE_WIDTH   head record code
//  out_ts       out  TS_WIDTH     head record timestamp
//  out_lost     out  1            >=1 event was dropped before this record
//  timestamp    out  TS_WIDTH     live timestamp
//  tick         out  1            one-cycle pulse on each timestamp increment
//  drop_count   out  DROP_WIDTH   events dropped on full FIFO, saturating
//  fifo_level   out  log2(FIFO_DEPTH)+1   records currently held, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset:
//   - All outputs, prescaler, pointers and lost_pending go to 0; FIFO becomes empty.
//   - A reset mid-operation discards queued records immediately.
//  Timebase:
//   - While enable=1, the prescaler counts 0..PRESCALE-1.
//   - On the edge where the prescaler is PRESCALE-1, it returns to 0 and timestamp increments.
//   - tick is registered: it is high for exactly the cycle in which the new timestamp value is visible.
//   - Timestamp wraps from all-ones to 0 with no side effect.
//   - While enable=0, everything holds and tick=0.
//   - clear overrides enable and increment: prescaler=0, timestamp=0, tick=0 next cycle.
//  Capture:
//   - On an edge with ev_valid=1, record {ev_code, timestamp value before that edge,
//     lost_pending} is written if a slot is free.
//   - A slot counts as free if the FIFO is not full, or if the FIFO is full and a pop
//     occurs on the same edge (simultaneous push+pop when full is accepted).
//   - If no slot is free, the event is dropped: drop_count += 1, saturating at all-ones,
//     and lost_pending is set to 1.
//   - lost_pending clears on the edge that writes a record carrying it.
//   - If clear and a drop happen on the same edge, clear wins: drop_count=0, lost_pending=0.
//  Output:
//   - FIFO is first-word-fall-through. out_valid rises one cycle after a push into an empty FIFO.
//   - out_code, out_ts and out_lost are stable while out_valid=1 and out_ready=0.
//   - A pop occurs when out_valid && out_ready; the next record appears the following cycle.
//   - out_ready while out_valid=0 has no effect.
//   - fifo_level updates on the same edge as push/pop; simultaneous push+pop leaves it unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - clear does not touch FIFO contents.
// TESTING
//  1. Timebase: reset, enable=1 for 480 cycles -> timestamp=10, exactly 10 tick pulses,
//     48 cycles apart; enable=0 for 100 cycles -> timestamp stays 10.
//  2. Wrap: TS_WIDTH=4, run 16*PRESCALE cycles -> timestamp 15->0, tick still pulses at
//     the wrap, no other flag.
//  3. Capture latency: ev_valid=1, ev_code=8'hA5 when timestamp=3 -> next cycle out_valid=1,
//     out_code=A5, out_ts=3, out_lost=0, fifo_level=1; out_ready=1 for 1 cycle -> fifo_level=0.
//  4. Overflow: out_ready=0, 11 events -> fifo_level=8, drop_count=3; drain 8 records, then
//     one new event -> its out_lost=1; a subsequent event -> out_lost=0.
//  5. Full push+pop: FIFO full, ev_valid=1 and out_ready=1 on the same edge -> event accepted,
//     fifo_level stays 8, drop_count unchanged.
//  6. Reset mid-run: 5 records queued, assert reset -> out_valid=0, fifo_level=0, timestamp=0,
//     drop_count=0 in the same cycle.

Source files
------------

// File: rtl/event_timestamper.sv
`default_nettype none
// ============================================================================
//  Module   : event_timestamper
//  Purpose  : Free-running timebase with a prescaler, plus an event capture
//             queue. Each event strobe is tagged with the live timestamp and
//             with a "lost" flag that records whether any earlier event was
//             dropped. The tagged event is queued in a small first-word-fall-
//             through FIFO, and the consumer drains that FIFO over a
//             valid/ready port. Events that arrive while the FIFO is full are
//             counted in a saturating counter and flagged on the next stored
//             record, so no event is lost without trace.
//
//  Ports    : osc48m      in   clock (48 MHz)
//             reset       in   asynchronous active-high reset
//             enable      in   1 = timebase advances, 0 = timebase holds
//             clear       in   synchronous zero of the timebase, drop counter
//                              and lost flag (FIFO contents untouched)
//             ev_valid    in   event strobe, sampled on every rising edge
//             ev_code     in   event code, qualified by ev_valid
//             out_valid   out  a head record is available
//             out_ready   in   consumer takes the head when out_valid=1
//             out_code    out  code of the head record
//             out_ts      out  timestamp of the head record
//             out_lost    out  at least one event was dropped before the head
//             timestamp   out  live timestamp
//             tick        out  one-cycle pulse when a new timestamp shows
//             drop_count  out  number of dropped events, saturating
//             fifo_level  out  records held, 0..FIFO_DEPTH
//
//  Revision : 1.0  initial release
// ============================================================================
module event_timestamper #(
    parameter int PRESCALE   = 48,  // osc48m cycles per timestamp step, >= 2
    parameter int TS_WIDTH   = 32,  // timestamp width, wraps modulo 2^TS_WIDTH
    parameter int CODE_WIDTH = 8,   // event code width
    parameter int FIFO_DEPTH = 8,   // record slots, power of 2, >= 2
    parameter int DROP_WIDTH = 8    // dropped-event counter width
) (
    input  logic                         osc48m,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         ev_valid,
    input  logic [CODE_WIDTH-1:0]        ev_code,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CODE_WIDTH-1:0]        out_code,
    output logic [TS_WIDTH-1:0]          out_ts,
    output logic                         out_lost,
    output logic [TS_WIDTH-1:0]          timestamp,
    output logic                         tick,
    output logic [DROP_WIDTH-1:0]        drop_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    // ------------------------------------------------------------------------
    //  Derived constants
    // ------------------------------------------------------------------------
    localparam int c_PS_W  = $clog2(PRESCALE);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_LW    = c_AW + 1;
    // A record is {lost, timestamp, code}, least significant field last.
    localparam int c_REC_W = 1 + TS_WIDTH + CODE_WIDTH;

    localparam logic [c_PS_W-1:0]     c_PS_LAST  = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0]     c_PS_ONE   = c_PS_W'(1);
    localparam logic [TS_WIDTH-1:0]   c_TS_ONE   = TS_WIDTH'(1);
    localparam logic [c_AW-1:0]       c_PTR_ONE  = c_AW'(1);
    localparam logic [c_LW-1:0]       c_LVL_ONE  = c_LW'(1);
    localparam logic [c_LW-1:0]       c_LVL_FULL = c_LW'(FIFO_DEPTH);
    localparam logic [DROP_WIDTH-1:0] c_DROP_ONE = DROP_WIDTH'(1);
    localparam logic [DROP_WIDTH-1:0] c_DROP_MAX = {DROP_WIDTH{1'b1}};

    // ------------------------------------------------------------------------
    //  Timebase state
    // ------------------------------------------------------------------------
    logic [c_PS_W-1:0]   presc_q,  presc_d;
    logic [TS_WIDTH-1:0] ts_q,     ts_d;
    logic                tick_q,   tick_d;

    // ------------------------------------------------------------------------
    //  Capture queue state
    // ------------------------------------------------------------------------
    logic [c_REC_W-1:0]    mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]       wr_ptr_q,  wr_ptr_d;
    logic [c_AW-1:0]       rd_ptr_q,  rd_ptr_d;
    logic [c_LW-1:0]       level_q,   level_d;
    logic [DROP_WIDTH-1:0] drop_q,    drop_d;
    logic                  lost_q,    lost_d;

    // ------------------------------------------------------------------------
    //  Handshake decode
    // ------------------------------------------------------------------------
    logic               w_out_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_slot_free;
    logic               w_push;
    logic               w_drop;
    logic [c_REC_W-1:0] w_wr_rec;
    logic [c_REC_W-1:0] w_head_rec;

    assign w_out_valid = (level_q != '0);
    assign w_full      = (level_q == c_LVL_FULL);
    assign w_pop       = w_out_valid & out_ready;
    // A full FIFO still accepts an event when the head leaves on the same
    // edge: the freed slot is the one the write pointer already addresses.
    assign w_slot_free = ~w_full | w_pop;
    assign w_push      = ev_valid & w_slot_free;
    assign w_drop      = ev_valid & ~w_slot_free;

    // The stamp is the timestamp as it stands before the capturing edge.
    assign w_wr_rec    = {lost_q, ts_q, ev_code};
    assign w_head_rec  = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------------
    //  Timebase next state
    // ------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        ts_d    = ts_q;
        tick_d  = 1'b0;
        if (clear) begin
            presc_d = '0;
            ts_d    = '0;
        end else if (enable) begin
            if (presc_q == c_PS_LAST) begin
                presc_d = '0;
                ts_d    = ts_q + c_TS_ONE;  // wraps silently at all-ones
                tick_d  = 1'b1;             // high while the new value shows
            end else begin
                presc_d = presc_q + c_PS_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    //  Queue bookkeeping next state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are c_AW bits wide, so the increment wraps at FIFO_DEPTH.
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LVL_ONE;
            2'b01:   level_d = level_q - c_LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // ------------------------------------------------------------------------
    //  Drop accounting next state
    // ------------------------------------------------------------------------
    always_comb begin
        drop_d = drop_q;
        lost_d = lost_q;
        if (clear) begin
            // clear beats a drop arriving on the same edge
            drop_d = '0;
            lost_d = 1'b0;
        end else begin
            if (w_drop && (drop_q != c_DROP_MAX)) begin
                drop_d = drop_q + c_DROP_ONE;
            end
            // A push and a drop are mutually exclusive on one edge. The pushed
            // record carries the pending flag, so the flag is consumed here.
            if (w_push) begin
                lost_d = 1'b0;
            end else if (w_drop) begin
                lost_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    //  State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge osc48m or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            ts_q     <= '0;
            tick_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            lost_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            ts_q     <= ts_d;
            tick_q   <= tick_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            lost_q   <= lost_d;
        end
    end

    // Record storage carries no reset: an empty FIFO never exposes a slot,
    // and the head outputs are forced to zero while out_valid is low.
    always_ff @(posedge osc48m) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_wr_rec;
        end
    end

    // ------------------------------------------------------------------------
    //  Outputs
    // ------------------------------------------------------------------------
    assign out_valid  = w_out_valid;
    assign out_code   = w_out_valid ? w_head_rec[CODE_WIDTH-1:0]                   : '0;
    assign out_ts     = w_out_valid ? w_head_rec[CODE_WIDTH +: TS_WIDTH]           : '0;
    assign out_lost   = w_out_valid ? w_head_rec[c_REC_W-1]                        : 1'b0;
    assign timestamp  = ts_q;
    assign tick       = tick_q;
    assign drop_count = drop_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire
